// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage feeding the IF/ID register. Holds the program
//   counter, waits for a start request, then streams reads to a synchronous
//   instruction memory. Fetched words go to decode with their PCs. The stage
//   also handles decode stalls through a one-entry skid buffer, branch
//   redirects, and stopping on a HALT opcode.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   switchStart   in   start request, level-sampled while IDLE
//   stall         in   decode cannot accept; IF/ID holds
//   branch_taken  in   redirect fetch to branch_target this edge
//   branch_target in   redirect address
//   imem_addr     out  memory read address (= fetch_pc)
//   imem_rdata    in   word for the address presented in the previous cycle
//   instr_id      out  IF/ID instruction
//   pc_id         out  PC of instr_id
//   valid_id      out  instr_id is real (0 = bubble)
//   halted        out  stage is in HALT
//
// state | meaning
// IDLE  | waiting for switchStart, no fetches
// RUN   | fetching one word per cycle
// HALT  | HALT word reached decode; fetching stopped until rst

module fetch_stage #(
    parameter int          ADDR_W  = 10,
    parameter int          INSTR_W = 21,
    parameter logic [4:0]  HALT_OP = 5'b11111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               switchStart,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_id,
    output logic [ADDR_W-1:0]  pc_id,
    output logic               valid_id,
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t               state_q,      state_d;
    logic [ADDR_W-1:0]    fetch_pc_q,   fetch_pc_d;
    logic                 req_valid_q,  req_valid_d;
    logic [ADDR_W-1:0]    req_pc_q,     req_pc_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [INSTR_W-1:0]   hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0]    hold_pc_q,    hold_pc_d;
    logic [INSTR_W-1:0]   instr_id_q,   instr_id_d;
    logic [ADDR_W-1:0]    pc_id_q,      pc_id_d;
    logic                 valid_id_q,   valid_id_d;
    logic                 halted_q,     halted_d;

    // Candidate word for IF/ID on an unstalled edge: skid buffer first,
    // then the word returning from memory.
    logic                 ld_valid;
    logic [INSTR_W-1:0]   ld_instr;
    logic [ADDR_W-1:0]    ld_pc;
    logic                 ld_halt;

    always_comb begin
        ld_valid = 1'b0;
        ld_instr = imem_rdata;
        ld_pc    = req_pc_q;
        if (hold_valid_q) begin
            ld_valid = 1'b1;
            ld_instr = hold_instr_q;
            ld_pc    = hold_pc_q;
        end else if (req_valid_q) begin
            ld_valid = 1'b1;
        end
        ld_halt = ld_valid && (ld_instr[INSTR_W-1 -: 5] == HALT_OP);
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_valid_d  = req_valid_q;
        req_pc_d     = req_pc_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        instr_id_d   = instr_id_q;
        pc_id_d      = pc_id_q;
        valid_id_d   = valid_id_q;

        unique case (state_q)
            ST_IDLE: begin
                if (switchStart) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (branch_taken) begin
                    // Everything fetched so far is wrong-path.
                    fetch_pc_d   = branch_target;
                    req_valid_d  = 1'b0;
                    hold_valid_d = 1'b0;
                    valid_id_d   = 1'b0;
                end else if (stall) begin
                    req_valid_d = 1'b0;
                    if (req_valid_q) begin
                        hold_valid_d = 1'b1;
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = req_pc_q;
                    end
                end else begin
                    hold_valid_d = 1'b0;
                    if (ld_valid) begin
                        instr_id_d = ld_instr;
                        pc_id_d    = ld_pc;
                        valid_id_d = 1'b1;
                    end else begin
                        valid_id_d = 1'b0;
                    end

                    if (ld_halt) begin
                        state_d     = ST_HALT;
                        req_valid_d = 1'b0;
                    end else if (hold_valid_q) begin
                        // Draining the skid buffer: the memory output this
                        // cycle belongs to an address nobody requested, so the
                        // read at fetch_pc is relaunched on the next edge. This
                        // costs one bubble after a stall release.
                        req_valid_d = 1'b0;
                    end else begin
                        req_valid_d = 1'b1;
                        req_pc_d    = fetch_pc_q;
                        fetch_pc_d  = fetch_pc_q + ADDR_W'(1);
                    end
                end
            end

            ST_HALT: begin
                if (!stall) begin
                    valid_id_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= '0;
            req_valid_q  <= 1'b0;
            req_pc_q     <= '0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            instr_id_q   <= '0;
            pc_id_q      <= '0;
            valid_id_q   <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_valid_q  <= req_valid_d;
            req_pc_q     <= req_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_id_q   <= instr_id_d;
            pc_id_q      <= pc_id_d;
            valid_id_q   <= valid_id_d;
            halted_q     <= halted_d;
        end
    end

    assign imem_addr = fetch_pc_q;
    assign instr_id  = instr_id_q;
    assign pc_id     = pc_id_q;
    assign valid_id  = valid_id_q;
    assign halted    = halted_q;

endmodule
